clk_div_multi: RTL and testbench

//  Multi-channel programmable clock divider and the successor of the fixed-divisor clk_div.

---
 rtl/clk_div_multi.sv | 129 ++++++++++++
 tb/tb_clk_div_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable divider producing per-channel rate enables and period-start ticks.
// Optional macro CLKDIV_SYNC_EN adds i_sync, a pulse that restarts every running channel at phase 0.
module clk_div_multi #(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 8,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
`ifdef CLKDIV_SYNC_EN
    input  logic              i_sync,
`endif
    input  logic [N_CH-1:0]   i_en,
    input  logic              i_cfg_valid,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [WIDTH-1:0]  i_cfg_div,
    output logic              o_cfg_ready,
    output logic [N_CH-1:0]   o_out,
    output logic [N_CH-1:0]   o_tick
);

    localparam int PEND_W = 1 << CH_W;

    logic [N_CH-1:0]   pend_q;
    logic [N_CH-1:0]   cfg_acc;
    logic [PEND_W-1:0] pend_ext;
    logic              sync_w;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = i_sync;
`else
    assign sync_w = 1'b0;
`endif

    // Channel indices beyond N_CH report ready and the load is simply dropped.
    always_comb begin
        pend_ext             = '0;
        pend_ext[N_CH-1:0]   = pend_q;
        o_cfg_ready          = ~pend_ext[i_cfg_ch];
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi = gi + 1) begin : g_ch
            logic [WIDTH-1:0] div_q, div_d;
            logic [WIDTH-1:0] phase_q, phase_d;
            logic [WIDTH-1:0] pdiv_q, pdiv_d;
            logic             pend_bit_q, pend_bit_d;
            logic             out_q, out_d;
            logic             tick_q, tick_d;
            logic [WIDTH:0]   half;
            logic             run;
            logic             last;

            assign cfg_acc[gi] = i_cfg_valid && o_cfg_ready && (i_cfg_ch == CH_W'(gi));
            assign pend_q[gi]  = pend_bit_q;
            assign o_out[gi]   = out_q;
            assign o_tick[gi]  = tick_q;

            always_comb begin
                div_d      = div_q;
                phase_d    = phase_q;
                pdiv_d     = pdiv_q;
                pend_bit_d = pend_bit_q;
                out_d      = 1'b0;
                tick_d     = 1'b0;
                half       = ({1'b0, div_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
                run        = i_en[gi] && (div_q >= WIDTH'(2));
                last       = (phase_q == (div_q - WIDTH'(1)));

                if (!run) begin
                    // Idle or off channel: hold phase 0 so the next run starts a fresh period.
                    phase_d = '0;
                    if (pend_bit_q) begin
                        div_d      = pdiv_q;
                        pend_bit_d = 1'b0;
                    end
                end else if (sync_w) begin
                    out_d   = 1'b1;
                    tick_d  = 1'b1;
                    phase_d = WIDTH'(1);
                    if (pend_bit_q) begin
                        div_d      = pdiv_q;
                        pend_bit_d = 1'b0;
                    end
                end else begin
                    out_d  = ({1'b0, phase_q} < half);
                    tick_d = (phase_q == '0);
                    if (last) begin
                        // Divisor swaps only here, so the next period is whole.
                        phase_d = '0;
                        if (pend_bit_q) begin
                            div_d      = pdiv_q;
                            pend_bit_d = 1'b0;
                        end
                    end else begin
                        phase_d = phase_q + WIDTH'(1);
                    end
                end

                // Accept only happens with the slot empty, so it never collides with an apply.
                if (cfg_acc[gi]) begin
                    pdiv_d     = i_cfg_div;
                    pend_bit_d = 1'b1;
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    div_q      <= WIDTH'(DEFAULT_DIV);
                    phase_q    <= '0;
                    pdiv_q     <= '0;
                    pend_bit_q <= 1'b0;
                    out_q      <= 1'b0;
                    tick_q     <= 1'b0;
                end else begin
                    div_q      <= div_d;
                    phase_q    <= phase_d;
                    pdiv_q     <= pdiv_d;
                    pend_bit_q <= pend_bit_d;
                    out_q      <= out_d;
                    tick_q     <= tick_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: the driver queues expected outputs per edge, a monitor compares on negedge.
module tb_clk_div_multi;

    logic       clk;
    logic       rst;
    logic       sync;
    logic [3:0] en;
    logic       cfg_valid;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic [3:0] out;
    logic [3:0] tick;

    clk_div_multi #(.N_CH(4), .WIDTH(8), .DEFAULT_DIV(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
`ifdef CLKDIV_SYNC_EN
        .i_sync      (sync),
`endif
        .i_en        (en),
        .i_cfg_valid (cfg_valid),
        .i_cfg_ch    (cfg_ch),
        .i_cfg_div   (cfg_div),
        .o_cfg_ready (cfg_ready),
        .o_out       (out),
        .o_tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] out;
        logic [3:0] tick;
        bit         chk_rdy;
        bit         rdy;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   dv[4];

    // Expected {out, tick} for a channel emitting phase p of divisor d; p<0 means idle.
    function automatic logic [1:0] chx(input int d, input int p);
        if (p < 0 || d < 2) return 2'b00;
        return {(p < (d + 1) / 2) ? 1'b1 : 1'b0, (p == 0) ? 1'b1 : 1'b0};
    endfunction

    task automatic step(input int p0, input int p1, input int p2, input int p3,
                        input bit chk_rdy, input bit erdy, input string tag);
        exp_t       e;
        int         pv[4];
        logic [1:0] b;
        pv = '{p0, p1, p2, p3};
        for (int i = 0; i < 4; i++) begin
            b         = chx(dv[i], pv[i]);
            e.out[i]  = b[1];
            e.tick[i] = b[0];
        end
        e.chk_rdy = chk_rdy;
        e.rdy     = erdy;
        e.tag     = tag;
        @(posedge clk);
        #1;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            checks++;
            if (out !== cur.out || tick !== cur.tick || (cur.chk_rdy && cfg_ready !== cur.rdy)) begin
                errors++;
                $display("FAIL %s: got out=%b tick=%b rdy=%b, want out=%b tick=%b rdy=%b%s",
                         cur.tag, out, tick, cfg_ready, cur.out, cur.tick, cur.rdy,
                         cur.chk_rdy ? "" : " (rdy unchecked)");
            end else begin
                $display("ok %s out=%b tick=%b rdy=%b", cur.tag, out, tick, cfg_ready);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sync = 1'b0; en = 4'b0000;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
        dv = '{8, 8, 8, 8};

        step(-1, -1, -1, -1, 1, 1, "reset0");
        step(-1, -1, -1, -1, 1, 1, "reset1");
        rst = 1'b0;

        // Default divisor 8 on ch0: 4 high, 4 low, tick every 8th edge.
        en = 4'b0001;
        for (int k = 0; k < 16; k++) step(k % 8, -1, -1, -1, 0, 0, "t1_div8");
        en = 4'b0000;
        step(-1, -1, -1, -1, 0, 0, "t1_off");

        // ch1 load div=5 while idle, then run alongside ch0.
        cfg_ch = 2'd1; cfg_div = 8'd5; cfg_valid = 1'b1;
        step(-1, -1, -1, -1, 1, 0, "t2_accept");
        cfg_valid = 1'b0;
        step(-1, -1, -1, -1, 1, 1, "t2_apply");
        dv[1] = 5;
        en = 4'b0011;
        for (int k = 0; k < 20; k++) step(k % 8, k % 5, -1, -1, 0, 0, "t2_run");

        // ch2 mid-period reload to 4, with a held second request for 6.
        en = 4'b0100; cfg_ch = 2'd2;
        for (int k = 0; k < 24; k++) begin
            int  p2;
            bit  rdy;
            if (k == 2) begin cfg_valid = 1'b1; cfg_div = 8'd4; end
            if (k < 8)       begin dv[2] = 8; p2 = k; end
            else if (k < 12) begin dv[2] = 4; p2 = k - 8; end
            else             begin dv[2] = 6; p2 = (k - 12) % 6; end
            rdy = !((k >= 2 && k <= 6) || (k >= 8 && k <= 10));
            step(-1, -1, p2, -1, 1, rdy, "t3_reload");
            if (k == 2) cfg_div = 8'd6;
            if (k == 8) cfg_valid = 1'b0;
        end

        // ch3 loads 1, 0, then 3; ch0 disabled and re-enabled.
        en = 4'b1001; cfg_ch = 2'd3; dv[0] = 8; dv[3] = 8;
        for (int k = 0; k < 20; k++) begin
            int p0;
            int p3;
            bit rdy;
            if (k == 0)  begin cfg_valid = 1'b1; cfg_div = 8'd1; end
            if (k == 9)  begin cfg_valid = 1'b1; cfg_div = 8'd0; end
            if (k == 11) begin cfg_valid = 1'b1; cfg_div = 8'd3; end
            if (k == 14) en[0] = 1'b0;
            if (k == 16) en[0] = 1'b1;
            if (k < 14)      p0 = k % 8;
            else if (k < 16) p0 = -1;
            else             p0 = k - 16;
            if (k < 8)       p3 = k;
            else if (k < 13) p3 = -1;
            else begin dv[3] = 3; p3 = (k - 13) % 3; end
            rdy = !(k <= 6 || k == 9 || k == 11);
            step(p0, -1, -1, p3, 1, rdy, "t4_offdiv");
            if (k == 0 || k == 9 || k == 11) cfg_valid = 1'b0;
        end

        // Reset at p=3 of ch0 with a load pending: pending dropped, both divisors back to 8.
        en = 4'b0000;
        step(-1, -1, -1, -1, 0, 0, "t5_idle");
        en = 4'b0001; cfg_ch = 2'd0; dv[0] = 8;
        for (int k = 0; k < 20; k++) begin
            int p0;
            int p3;
            if (k == 0) begin cfg_valid = 1'b1; cfg_div = 8'd2; end
            if (k == 3) rst = 1'b1;
            if (k == 4) begin rst = 1'b0; en = 4'b1001; end
            if (k < 3)       begin p0 = k; p3 = -1; end
            else if (k == 3) begin p0 = -1; p3 = -1; dv[3] = 8; end
            else             begin p0 = (k - 4) % 8; p3 = (k - 4) % 8; end
            step(p0, -1, -1, p3, 1, (k > 2), "t5_reset");
            if (k == 0) cfg_valid = 1'b0;
        end

`ifdef CLKDIV_SYNC_EN
        // ch0 div=4 and ch1 div=6 started one edge apart, then phase-aligned by i_sync.
        en = 4'b0000;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
        step(-1, -1, -1, -1, 0, 0, "t6_load0");
        cfg_ch = 2'd1; cfg_div = 8'd6;
        step(-1, -1, -1, -1, 0, 0, "t6_load1");
        cfg_valid = 1'b0;
        step(-1, -1, -1, -1, 0, 0, "t6_apply");
        dv[0] = 4; dv[1] = 6;
        for (int k = 0; k < 31; k++) begin
            int p0;
            int p1;
            if (k == 0) en = 4'b0001;
            if (k == 1) en = 4'b0011;
            if (k == 7) sync = 1'b1;
            if (k < 7) begin p0 = k % 4; p1 = (k >= 1) ? (k - 1) % 6 : -1; end
            else       begin p0 = (k - 7) % 4; p1 = (k - 7) % 6; end
            step(p0, p1, -1, -1, 0, 0, "t6_sync");
            if (k == 7) sync = 1'b0;
        end
`endif

        en = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
